// File: rtl/calu_arbiter_pkg.sv
// Shared widths, complex-word slice positions and FSM encoding for the
// two-client complex-ALU arbiter.
package calu_arbiter_pkg;
  localparam int DATA_W = 64;
  localparam int OPR_W  = 5;
  localparam int RE_HI  = 63;
  localparam int RE_LO  = 32;
  localparam int IM_HI  = 31;
  localparam int IM_LO  = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
endpackage

// File: rtl/calu_arbiter_if.sv
// Start/done bus between the arbiter (master) and the shared complex ALU (slave).
interface calu_arbiter_if;
  import calu_arbiter_pkg::*;

  logic              alu_start;
  logic [OPR_W-1:0]  alu_opr;
  logic [DATA_W-1:0] alu_inA;
  logic [DATA_W-1:0] alu_inB;
  logic [DATA_W-1:0] alu_outAB;
  logic              alu_done;

  modport master (
    output alu_start, alu_opr, alu_inA, alu_inB,
    input  alu_outAB, alu_done
  );

  modport slave (
    input  alu_start, alu_opr, alu_inA, alu_inB,
    output alu_outAB, alu_done
  );
endinterface

// File: rtl/calu_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to the requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick
);
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = ~last;
    else              pick = req[1];
  end
endmodule

// File: rtl/calu_arbiter.sv
// Shares one complex ALU between two requesters: round-robin grant, operand
// capture, single start pulse, result return and a done watchdog.
//
// state    | meaning
// ST_IDLE  | no operation; sample req0/req1 and capture the winner's operands
// ST_ISSUE | gnt and alu_start high for this one cycle, watchdog cleared
// ST_WAIT  | waiting for alu_done or watchdog terminal count
// ST_RESP  | done pulse to the owner, owner becomes last served
module calu_arbiter
  import calu_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [OPR_W-1:0]  opr0,
  input  logic [OPR_W-1:0]  opr1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] res0,
  output logic [DATA_W-1:0] res1,
  output logic              err0,
  output logic              err1,
  calu_arbiter_if.master    alu
);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              owner;
  logic              last;
  logic [CNT_W-1:0]  cnt;
  logic              start_q;
  logic [OPR_W-1:0]  opr_q;
  logic [DATA_W-1:0] ina_q;
  logic [DATA_W-1:0] inb_q;
  logic              win;
  logic              fin;

  rr_arb2 u_rr (
    .req  ({req1, req0}),
    .last (last),
    .pick (win)
  );

  // done wins over a coincident watchdog expiry
  assign fin = alu.alu_done || (cnt == TC);

  assign alu.alu_start = start_q;
  assign alu.alu_opr   = opr_q;
  assign alu.alu_inA   = ina_q;
  assign alu.alu_inB   = inb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      start_q <= 1'b0;
      opr_q   <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res0    <= '0;
      res1    <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            opr_q   <= win ? opr1 : opr0;
            ina_q   <= win ? a1 : a0;
            inb_q   <= win ? b1 : b0;
            owner   <= win;
            gnt0    <= ~win;
            gnt1    <= win;
            start_q <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fin) begin
            if (owner) begin
              res1  <= alu.alu_done ? alu.alu_outAB : '0;
              err1  <= ~alu.alu_done;
              done1 <= 1'b1;
            end else begin
              res0  <= alu.alu_done ? alu.alu_outAB : '0;
              err0  <= ~alu.alu_done;
              done0 <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          last  <= owner;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calu_arbiter.sv
// Directed bench for calu_arbiter with TIMEOUT=8; the ALU side is driven by hand.
module tb_calu_arbiter;
  import calu_arbiter_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [OPR_W-1:0]  opr0 = '0, opr1 = '0;
  logic [DATA_W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic              gnt0, gnt1, done0, done1, err0, err1;
  logic [DATA_W-1:0] res0, res1;

  int total = 0;
  int bad   = 0;
  int n_start = 0;

  calu_arbiter_if alu_bus ();

  calu_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clock (clock), .reset (reset),
    .req0  (req0),  .req1  (req1),
    .opr0  (opr0),  .opr1  (opr1),
    .a0    (a0),    .a1    (a1),
    .b0    (b0),    .b1    (b1),
    .gnt0  (gnt0),  .gnt1  (gnt1),
    .done0 (done0), .done1 (done1),
    .res0  (res0),  .res1  (res1),
    .err0  (err0),  .err1  (err1),
    .alu   (alu_bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (alu_bus.alu_start === 1'b1) n_start++;

  initial begin
    #200000;
    $display("FAIL watchdog sim_time_limit reached");
    $fatal(1, "simulation time limit");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // from ISSUE: lat+1 WAIT cycles elapse, then alu_done for one cycle; ends in RESP
  task automatic finish_op(input logic [63:0] val, input int lat);
    repeat (lat + 1) tick;
    alu_bus.alu_done  = 1'b1;
    alu_bus.alu_outAB = val;
    tick;
    alu_bus.alu_done  = 1'b0;
    alu_bus.alu_outAB = '0;
  endtask

  initial begin
    logic [63:0] cap;
    int seen;
    int gbad;
    int abad;
    alu_bus.alu_done  = 1'b0;
    alu_bus.alu_outAB = '0;

    // reset state
    tick;
    chk("rst_gnt", {62'd0, gnt1, gnt0}, 64'd0);
    chk("rst_done", {62'd0, done1, done0}, 64'd0);
    chk("rst_err", {62'd0, err1, err0}, 64'd0);
    chk("rst_res0", res0, 64'd0);
    chk("rst_res1", res1, 64'd0);
    chk("rst_start", {63'd0, alu_bus.alu_start}, 64'd0);
    chk("rst_inA", alu_bus.alu_inA, 64'd0);
    reset = 1'b1;
    tick;

    // 1: single request from client 0
    req0 = 1'b1; opr0 = 5'h01;
    a0 = 64'h00000003_00000004; b0 = 64'h00000001_00000002;
    tick;
    chk("t1_gnt0", {63'd0, gnt0}, 64'd1);
    chk("t1_gnt1", {63'd0, gnt1}, 64'd0);
    chk("t1_start", {63'd0, alu_bus.alu_start}, 64'd1);
    chk("t1_inA", alu_bus.alu_inA, 64'h00000003_00000004);
    chk("t1_inB", alu_bus.alu_inB, 64'h00000001_00000002);
    chk("t1_opr", {59'd0, alu_bus.alu_opr}, 64'd1);
    req0 = 1'b0;
    tick;
    chk("t1_gnt0_pulse", {63'd0, gnt0}, 64'd0);
    chk("t1_start_pulse", {63'd0, alu_bus.alu_start}, 64'd0);
    repeat (3) tick;
    alu_bus.alu_done = 1'b1; alu_bus.alu_outAB = 64'hFFFFFFFB_0000000A;
    tick;
    alu_bus.alu_done = 1'b0; alu_bus.alu_outAB = '0;
    chk("t1_done0", {63'd0, done0}, 64'd1);
    chk("t1_done1", {63'd0, done1}, 64'd0);
    chk("t1_res0", res0, 64'hFFFFFFFB_0000000A);
    chk("t1_err0", {63'd0, err0}, 64'd0);
    chk("t1_res1", res1, 64'd0);
    tick;
    chk("t1_done0_pulse", {63'd0, done0}, 64'd0);
    chk("t1_one_start", n_start, 1);

    // 2: simultaneous requests alternate, starting with client 0 after reset
    reset = 1'b0; #2; reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    opr0 = 5'h02; a0 = 64'h00000010_00000020; b0 = 64'h1;
    opr1 = 5'h03; a1 = 64'h00000030_00000040; b1 = 64'h2;
    tick;
    chk("t2a_gnt0", {63'd0, gnt0}, 64'd1);
    chk("t2a_gnt1", {63'd0, gnt1}, 64'd0);
    chk("t2a_inA", alu_bus.alu_inA, 64'h00000010_00000020);
    req0 = 1'b0;
    finish_op(64'hAAAA0000_00000001, 1);
    chk("t2a_done0", {63'd0, done0}, 64'd1);
    chk("t2a_res0", res0, 64'hAAAA0000_00000001);
    chk("t2a_res1", res1, 64'd0);
    tick;
    chk("t2_no_early_gnt1", {63'd0, gnt1}, 64'd0);
    tick;
    chk("t2b_gnt1", {63'd0, gnt1}, 64'd1);
    chk("t2b_inA", alu_bus.alu_inA, 64'h00000030_00000040);
    chk("t2b_opr", {59'd0, alu_bus.alu_opr}, 64'd3);
    req1 = 1'b0;
    finish_op(64'hBBBB0000_00000002, 0);
    chk("t2b_done1", {63'd0, done1}, 64'd1);
    chk("t2b_res1", res1, 64'hBBBB0000_00000002);
    chk("t2b_res0_kept", res0, 64'hAAAA0000_00000001);
    tick;
    req0 = 1'b1; req1 = 1'b1;
    tick;
    chk("t2c_gnt0", {63'd0, gnt0}, 64'd1);
    chk("t2c_gnt1", {63'd0, gnt1}, 64'd0);
    req0 = 1'b0;
    finish_op(64'hCCCC0000_00000003, 0);
    chk("t2c_done0", {63'd0, done0}, 64'd1);
    tick;
    tick;
    chk("t2d_gnt1", {63'd0, gnt1}, 64'd1);
    req1 = 1'b0;
    finish_op(64'hDDDD0000_00000004, 0);
    chk("t2d_res1", res1, 64'hDDDD0000_00000004);
    tick;

    // 3: watchdog expiry, then a stray done is dropped
    req0 = 1'b1;
    tick;
    chk("t3_gnt0", {63'd0, gnt0}, 64'd1);
    req0 = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (done0 || done1) seen++;
    end
    chk("t3_no_early_done", seen, 0);
    tick;
    chk("t3_done0", {63'd0, done0}, 64'd1);
    chk("t3_err0", {63'd0, err0}, 64'd1);
    chk("t3_res0_zero", res0, 64'd0);
    chk("t3_res1_kept", res1, 64'hDDDD0000_00000004);
    tick;
    alu_bus.alu_done = 1'b1; alu_bus.alu_outAB = 64'h12345678_9ABCDEF0;
    seen = 0;
    repeat (2) begin
      tick;
      if (done0 || done1 || gnt0 || gnt1) seen++;
    end
    alu_bus.alu_done = 1'b0; alu_bus.alu_outAB = '0;
    chk("t3_stray_done", seen, 0);
    chk("t3_stray_res0", res0, 64'd0);

    // 4: done on the last WAIT cycle beats the watchdog
    req1 = 1'b1;
    tick;
    chk("t4_gnt1", {63'd0, gnt1}, 64'd1);
    req1 = 1'b0;
    finish_op(64'h0000BEEF_0000CAFE, 7);
    chk("t4_done1", {63'd0, done1}, 64'd1);
    chk("t4_err1", {63'd0, err1}, 64'd0);
    chk("t4_res1", res1, 64'h0000BEEF_0000CAFE);
    chk("t4_err0_kept", {63'd0, err0}, 64'd1);
    tick;

    // 6: req1 during op0 waits for IDLE; captured operands stay stable
    req0 = 1'b1; a0 = 64'h11111111_22222222;
    tick;
    chk("t6_gnt0", {63'd0, gnt0}, 64'd1);
    req0 = 1'b0;
    cap = 64'h11111111_22222222;
    tick;
    req1 = 1'b1; a1 = 64'h33333333_44444444;
    a0 = 64'h55555555_66666666;
    gbad = 0; abad = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (gnt1) gbad++;
      if (alu_bus.alu_inA !== cap) abad++;
    end
    alu_bus.alu_done = 1'b1; alu_bus.alu_outAB = 64'h77;
    tick;
    alu_bus.alu_done = 1'b0; alu_bus.alu_outAB = '0;
    if (gnt1) gbad++;
    if (alu_bus.alu_inA !== cap) abad++;
    chk("t6_done0", {63'd0, done0}, 64'd1);
    tick;
    if (gnt1) gbad++;
    chk("t6_no_gnt1_busy", gbad, 0);
    chk("t6_inA_stable", abad, 0);
    tick;
    chk("t6_gnt1", {63'd0, gnt1}, 64'd1);
    chk("t6_inA1", alu_bus.alu_inA, 64'h33333333_44444444);
    req1 = 1'b0;

    // 5: reset during WAIT clears everything at once, no done; then a fresh req1
    tick;
    tick;
    #3;
    reset = 1'b0;
    #1;
    chk("t5_async_res1", res1, 64'd0);
    chk("t5_async_err0", {63'd0, err0}, 64'd0);
    chk("t5_async_inA", alu_bus.alu_inA, 64'd0);
    chk("t5_async_flags", {59'd0, alu_bus.alu_start, gnt1, gnt0, done1, done0}, 64'd0);
    tick;
    chk("t5_no_done", {62'd0, done1, done0}, 64'd0);
    reset = 1'b1;
    req1 = 1'b1; a1 = 64'h0000ABCD_00001234; opr1 = 5'h1F;
    tick;
    chk("t5_gnt1", {63'd0, gnt1}, 64'd1);
    chk("t5_inA", alu_bus.alu_inA, 64'h0000ABCD_00001234);
    req1 = 1'b0;
    finish_op(64'h00000005_00000006, 2);
    chk("t5_done1", {63'd0, done1}, 64'd1);
    chk("t5_res1", res1, 64'h00000005_00000006);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
